// File: rtl/gpio_pkg.sv
// Shared constants for the GPIO bank: register indices and bus/prescaler widths.
package gpio_pkg;

  localparam int BUS_W = 32;
  localparam int PRE_W = 16;

  localparam logic [2:0] GPIO_IN       = 3'd0;
  localparam logic [2:0] GPIO_OUT      = 3'd1;
  localparam logic [2:0] GPIO_DIR      = 3'd2;
  localparam logic [2:0] GPIO_IRQ_EN   = 3'd3;
  localparam logic [2:0] GPIO_IRQ_RISE = 3'd4;
  localparam logic [2:0] GPIO_IRQ_FALL = 3'd5;
  localparam logic [2:0] GPIO_IRQ_STAT = 3'd6;
  localparam logic [2:0] GPIO_DEB_DIV  = 3'd7;

endpackage

// File: rtl/gpio_debounce.sv
// Per-pin input path: 2-FF synchroniser followed by a tick-driven debounce filter
// that owns the accepted (IN) level of the pin.
module gpio_debounce #(
  parameter int DEBOUNCE_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic pad,
  input  logic tick,
  input  logic bypass,
  input  logic cnt_clr,
  output logic level
);

  localparam int CNT_W = (DEBOUNCE_LEN < 2) ? 1 : $clog2(DEBOUNCE_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync1 <= pad;
      sync2 <= sync1;
      if (bypass) begin
        level <= sync2;
        cnt   <= '0;
      end else if (cnt_clr) begin
        cnt <= '0;
      end else if (tick) begin
        // the tick that would bring the count to DEBOUNCE_LEN accepts the level
        if (sync2 != level) begin
          if (cnt == CNT_LAST) begin
            level <= sync2;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end else begin
          cnt <= '0;
        end
      end
    end
  end

endmodule

// File: rtl/gpio_bank.sv
// Parametrised GPIO bank: register file, debounce prescaler, edge detection with
// sticky W1C status and a registered level interrupt.
module gpio_bank
  import gpio_pkg::*;
#(
  parameter int               WIDTH        = 8,
  parameter int               DEBOUNCE_LEN = 4,
  parameter logic [WIDTH-1:0] DIR_RESET    = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bus_stb,
  input  logic             bus_we,
  input  logic [2:0]       bus_addr,
  input  logic [31:0]      bus_wdata,
  output logic [31:0]      bus_rdata,
  output logic             bus_ack,
  input  logic [WIDTH-1:0] gpio_i,
  output logic [WIDTH-1:0] gpio_o,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq
);

  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] dir_q;
  logic [WIDTH-1:0] en_q;
  logic [WIDTH-1:0] rise_q;
  logic [WIDTH-1:0] fall_q;
  logic [WIDTH-1:0] stat_q;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] in_lvl;
  logic [PRE_W-1:0] deb_div;
  logic [PRE_W-1:0] pre;

  logic             wr;
  logic             rd;
  logic             deb_wr;
  logic             bypass;
  logic             tick;
  logic [WIDTH-1:0] wdat;
  logic [WIDTH-1:0] stat_clr;
  logic [WIDTH-1:0] edge_set;
  logic [BUS_W-1:0] rd_mux;
  logic             unused_wdata;

  assign wr           = bus_stb & bus_we;
  assign rd           = bus_stb & ~bus_we;
  assign wdat         = bus_wdata[WIDTH-1:0];
  assign deb_wr       = wr && (bus_addr == GPIO_DEB_DIV);
  assign bypass       = (deb_div == '0);
  assign tick         = !bypass && (pre == deb_div);
  assign stat_clr     = (wr && (bus_addr == GPIO_IRQ_STAT)) ? wdat : '0;
  assign edge_set     = (in_lvl & ~prev_q & rise_q) | (~in_lvl & prev_q & fall_q);
  assign unused_wdata = ^bus_wdata;

  assign gpio_o  = out_q;
  assign gpio_oe = ~dir_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    gpio_debounce #(
      .DEBOUNCE_LEN(DEBOUNCE_LEN)
    ) u_deb (
      .clk    (clk),
      .rst    (rst),
      .pad    (gpio_i[i]),
      .tick   (tick),
      .bypass (bypass),
      .cnt_clr(deb_wr),
      .level  (in_lvl[i])
    );
  end

  // prescaler runs 0..deb_div; a DEB_DIV write restarts the debounce timebase
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre <= '0;
    end else if (deb_wr || bypass || tick) begin
      pre <= '0;
    end else begin
      pre <= pre + PRE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q   <= '0;
      dir_q   <= DIR_RESET;
      en_q    <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      stat_q  <= '0;
      prev_q  <= '0;
      deb_div <= '0;
      irq     <= 1'b0;
    end else begin
      prev_q <= in_lvl;
      stat_q <= (stat_q & ~stat_clr) | edge_set;
      irq    <= |(stat_q & en_q);
      if (wr) begin
        case (bus_addr)
          GPIO_OUT:      out_q   <= wdat;
          GPIO_DIR:      dir_q   <= wdat;
          GPIO_IRQ_EN:   en_q    <= wdat;
          GPIO_IRQ_RISE: rise_q  <= wdat;
          GPIO_IRQ_FALL: fall_q  <= wdat;
          GPIO_DEB_DIV:  deb_div <= bus_wdata[PRE_W-1:0];
          default:       ;
        endcase
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    case (bus_addr)
      GPIO_IN:       rd_mux[WIDTH-1:0] = in_lvl;
      GPIO_OUT:      rd_mux[WIDTH-1:0] = out_q;
      GPIO_DIR:      rd_mux[WIDTH-1:0] = dir_q;
      GPIO_IRQ_EN:   rd_mux[WIDTH-1:0] = en_q;
      GPIO_IRQ_RISE: rd_mux[WIDTH-1:0] = rise_q;
      GPIO_IRQ_FALL: rd_mux[WIDTH-1:0] = fall_q;
      GPIO_IRQ_STAT: rd_mux[WIDTH-1:0] = stat_q;
      GPIO_DEB_DIV:  rd_mux[PRE_W-1:0] = deb_div;
      default:       rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus_ack   <= 1'b0;
      bus_rdata <= '0;
    end else begin
      bus_ack <= bus_stb;
      if (rd) begin
        bus_rdata <= rd_mux;
      end
    end
  end

endmodule

// File: tb/tb_gpio_bank.sv
// Directed bench for gpio_bank: table-driven register vectors plus cycle-exact
// sequences for input latency, edge status, debounce and reset behaviour.
module tb_gpio_bank;
  import gpio_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        bus_stb;
  logic        bus_we;
  logic [2:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic [7:0]  gpio_i;
  logic [7:0]  gpio_o;
  logic [7:0]  gpio_oe;
  logic        irq;

  int n_pass  = 0;
  int n_total = 0;

  gpio_bank dut (
    .clk      (clk),
    .rst      (rst),
    .bus_stb  (bus_stb),
    .bus_we   (bus_we),
    .bus_addr (bus_addr),
    .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata),
    .bus_ack  (bus_ack),
    .gpio_i   (gpio_i),
    .gpio_o   (gpio_o),
    .gpio_oe  (gpio_oe),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic [7:0]  exp_o;
    logic [7:0]  exp_oe;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // drive at a falling edge, return at the next falling edge (one rising edge passed)
  task automatic step(input logic s, input logic w, input logic [2:0] a, input logic [31:0] d);
    bus_stb   = s;
    bus_we    = w;
    bus_addr  = a;
    bus_wdata = d;
    @(negedge clk);
  endtask

  task automatic access(input logic w, input logic [2:0] a, input logic [31:0] d,
                        output logic [31:0] r);
    step(1'b1, w, a, d);
    check("ack", bus_ack, 1);
    r = bus_rdata;
    step(1'b0, 1'b0, 3'd0, 32'd0);
    check("ack_drop", bus_ack, 0);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    logic [31:0] r;
    access(1'b1, a, d, r);
  endtask

  task automatic rd_chk(input string name, input logic [2:0] a, input logic [31:0] exp);
    logic [31:0] r;
    access(1'b0, a, 32'd0, r);
    check(name, r, exp);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 3'd0, 32'd0);
  endtask

  initial begin
    logic [31:0] r;
    int first;

    vecs[0]  = '{1'b0, GPIO_IN,       32'h0,  32'h00, 8'h00, 8'h00};
    vecs[1]  = '{1'b0, GPIO_OUT,      32'h0,  32'h00, 8'h00, 8'h00};
    vecs[2]  = '{1'b0, GPIO_DIR,      32'h0,  32'hFF, 8'h00, 8'h00};
    vecs[3]  = '{1'b0, GPIO_IRQ_EN,   32'h0,  32'h00, 8'h00, 8'h00};
    vecs[4]  = '{1'b0, GPIO_IRQ_RISE, 32'h0,  32'h00, 8'h00, 8'h00};
    vecs[5]  = '{1'b0, GPIO_IRQ_FALL, 32'h0,  32'h00, 8'h00, 8'h00};
    vecs[6]  = '{1'b0, GPIO_IRQ_STAT, 32'h0,  32'h00, 8'h00, 8'h00};
    vecs[7]  = '{1'b0, GPIO_DEB_DIV,  32'h0,  32'h00, 8'h00, 8'h00};
    vecs[8]  = '{1'b1, GPIO_OUT,      32'h5A, 32'h00, 8'h5A, 8'h00};
    vecs[9]  = '{1'b1, GPIO_DIR,      32'hF0, 32'h00, 8'h5A, 8'h0F};
    vecs[10] = '{1'b0, GPIO_OUT,      32'h0,  32'h5A, 8'h5A, 8'h0F};
    vecs[11] = '{1'b0, GPIO_DIR,      32'h0,  32'hF0, 8'h5A, 8'h0F};

    rst = 1'b0; bus_stb = 1'b0; bus_we = 1'b0; bus_addr = 3'd0; bus_wdata = 32'd0;
    gpio_i = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_ack", bus_ack, 0);
    check("rst_rdata", bus_rdata, 0);
    check("rst_irq", irq, 0);
    check("rst_oe", gpio_oe, 8'h00);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      access(vecs[i].we, vecs[i].addr, vecs[i].wdata, r);
      if (!vecs[i].we) check($sformatf("vec%0d_rdata", i), r, vecs[i].exp_rd);
      check($sformatf("vec%0d_gpio_o", i), gpio_o, vecs[i].exp_o);
      check($sformatf("vec%0d_gpio_oe", i), gpio_oe, vecs[i].exp_oe);
    end

    // bypass latency, strobe held high across consecutive reads
    wr(GPIO_DEB_DIV, 32'h0);
    wr(GPIO_IRQ_RISE, 32'hFF);
    wr(GPIO_IRQ_EN, 32'hFF);
    gpio_i = 8'hAA;
    step(1'b0, 1'b0, 3'd0, 32'd0);
    step(1'b0, 1'b0, 3'd0, 32'd0);
    step(1'b1, 1'b0, GPIO_IN, 32'd0);
    check("byp_e2_ack", bus_ack, 1);
    check("byp_in_at_e2", bus_rdata, 32'h00);
    step(1'b1, 1'b0, GPIO_IN, 32'd0);
    check("byp_e3_ack", bus_ack, 1);
    check("byp_in_at_e3", bus_rdata, 32'hAA);
    check("byp_irq_at_e3", irq, 0);
    step(1'b1, 1'b0, GPIO_IRQ_STAT, 32'd0);
    check("byp_stat_at_e4", bus_rdata, 32'hAA);
    check("byp_irq_at_e4", irq, 1);
    idle(1);
    wr(GPIO_IRQ_STAT, 32'h0A);
    rd_chk("w1c_partial", GPIO_IRQ_STAT, 32'hA0);
    check("w1c_partial_irq", irq, 1);
    step(1'b1, 1'b1, GPIO_IRQ_STAT, 32'hA0);
    check("irq_at_clear_edge", irq, 1);
    step(1'b0, 1'b0, 3'd0, 32'd0);
    check("irq_after_clear", irq, 0);

    // rise/fall selection
    wr(GPIO_IRQ_RISE, 32'h01);
    wr(GPIO_IRQ_FALL, 32'h03);
    gpio_i = 8'h00;
    idle(6);
    wr(GPIO_IRQ_STAT, 32'hFF);
    rd_chk("stat_clear_all", GPIO_IRQ_STAT, 32'h00);
    gpio_i = 8'h01; idle(6);
    rd_chk("pin0_rise", GPIO_IRQ_STAT, 32'h01);
    wr(GPIO_IRQ_STAT, 32'h01);
    gpio_i = 8'h00; idle(6);
    rd_chk("pin0_fall", GPIO_IRQ_STAT, 32'h01);
    check("pin0_irq", irq, 1);
    wr(GPIO_IRQ_STAT, 32'h01);
    gpio_i = 8'h02; idle(6);
    rd_chk("pin1_rise_masked", GPIO_IRQ_STAT, 32'h00);
    gpio_i = 8'h00; idle(6);
    rd_chk("pin1_fall", GPIO_IRQ_STAT, 32'h02);
    wr(GPIO_IRQ_STAT, 32'h02);
    wr(GPIO_IRQ_EN, 32'h00);
    gpio_i = 8'h01; idle(6);
    rd_chk("stat_without_en", GPIO_IRQ_STAT, 32'h01);
    check("irq_without_en", irq, 0);

    // debounce: glitch rejection
    gpio_i = 8'h00; idle(6);
    wr(GPIO_IRQ_RISE, 32'h04);
    wr(GPIO_IRQ_FALL, 32'h04);
    wr(GPIO_IRQ_STAT, 32'hFF);
    wr(GPIO_DEB_DIV, 32'h3);
    gpio_i = 8'h04; idle(10);
    gpio_i = 8'h00; idle(24);
    rd_chk("glitch_in", GPIO_IN, 32'h00);
    rd_chk("glitch_stat", GPIO_IRQ_STAT, 32'h00);

    // debounce: acceptance on the 4th tick after a DEB_DIV write
    step(1'b1, 1'b1, GPIO_DEB_DIV, 32'h3);
    gpio_i = 8'h04;
    step(1'b0, 1'b0, 3'd0, 32'd0);
    first = 0;
    for (int k = 1; k <= 24; k++) begin
      step(1'b1, 1'b0, GPIO_IN, 32'd0);
      if (first == 0 && bus_rdata[2]) first = k;
    end
    idle(1);
    check("deb_accept_cycle", 32'(first), 32'd16);
    rd_chk("deb_stat_rise", GPIO_IRQ_STAT, 32'h04);
    gpio_i = 8'h00; idle(30);
    rd_chk("deb_release_in", GPIO_IN, 32'h00);
    wr(GPIO_IRQ_STAT, 32'hFF);

    // debounce: rewriting DEB_DIV mid-count restarts the count
    step(1'b1, 1'b1, GPIO_DEB_DIV, 32'h3);
    gpio_i = 8'h04;
    idle(13);
    step(1'b1, 1'b1, GPIO_DEB_DIV, 32'h3);
    first = 0;
    for (int k = 1; k <= 30; k++) begin
      step(1'b1, 1'b0, GPIO_IN, 32'd0);
      if (first == 0 && bus_rdata[2]) first = k;
    end
    idle(1);
    check("deb_restart_cycle", 32'(first), 32'd17);

    // set wins over a same-cycle W1C clear
    wr(GPIO_DEB_DIV, 32'h0);
    gpio_i = 8'h00; idle(6);
    wr(GPIO_IRQ_RISE, 32'h08);
    wr(GPIO_IRQ_STAT, 32'hFF);
    rd_chk("coll_pre_stat", GPIO_IRQ_STAT, 32'h00);
    gpio_i = 8'h08;
    idle(3);
    step(1'b1, 1'b1, GPIO_IRQ_STAT, 32'h08);
    idle(1);
    rd_chk("coll_set_wins", GPIO_IRQ_STAT, 32'h08);
    wr(GPIO_IRQ_EN, 32'h08);
    idle(1);
    check("coll_irq", irq, 1);

    // asynchronous reset during a read and a debounce count
    wr(GPIO_DEB_DIV, 32'h3);
    gpio_i = 8'hFF; idle(6);
    step(1'b1, 1'b0, GPIO_OUT, 32'd0);
    check("pre_rst_ack", bus_ack, 1);
    check("pre_rst_rdata", bus_rdata, 32'h5A);
    rst = 1'b0;
    #1;
    check("async_rst_ack", bus_ack, 0);
    check("async_rst_rdata", bus_rdata, 32'h0);
    check("async_rst_gpio_o", gpio_o, 8'h00);
    check("async_rst_gpio_oe", gpio_oe, 8'h00);
    check("async_rst_irq", irq, 0);
    bus_stb = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, 3'd0, 32'd0);
      check($sformatf("no_stray_ack%0d", k), bus_ack, 0);
    end
    rd_chk("post_rst_in", GPIO_IN, 32'hFF);
    rd_chk("post_rst_stat", GPIO_IRQ_STAT, 32'h00);
    rd_chk("post_rst_dir", GPIO_DIR, 32'hFF);
    check("post_rst_irq", irq, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
